// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enabled, self-clearing SRAM.
package sram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Replace byte i of old_word with byte i of new_word wherever be[i] is set.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Plain storage array: one byte-enabled write port, one registered read port, no reset.
module sram_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned BE_W   = 2
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read returns the pre-write contents; same-address forwarding lives above.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_be_init.sv
// Parametrised simple dual-port SRAM with byte enables, write-first forwarding,
// a post-reset clear sweep and a configurable 1- or 2-cycle read latency.
module sram_be_init
    import sram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 14,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  init_done,
    output logic                  init_viol
);

    localparam int unsigned       BE_W      = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              init_done_q;
    logic              init_viol_q, init_viol_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [BE_W-1:0]   mem_wbe;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_acc;
    logic              wr_acc;

    logic [DATA_W-1:0] bank_rdata;
    logic              rd_v1_q;
    logic              fwd_hit_q;
    logic [BE_W-1:0]   fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [BE_W-1:0]   fwd_be_eff;
    logic [DATA_W-1:0] merged;

    // Clear FSM, write-port mux and access gating.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_viol_d = init_viol_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wbe     = wr_be;
        mem_wdata   = din;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wbe   = '1;
                mem_wdata = INIT_VAL;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
                if (wr_en || rd_en) begin
                    init_viol_d = 1'b1;
                end
            end
            RUN: begin
                wr_acc = wr_en;
                rd_acc = rd_en;
                mem_we = wr_en;
            end
        endcase

        // Memory is left untouched while reset is held.
        if (rst) begin
            mem_we = 1'b0;
            rd_acc = 1'b0;
            wr_acc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            init_viol_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= (state_d == RUN);
            init_viol_q <= init_viol_d;
        end
    end

    sram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_bank (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wbe_i   (mem_wbe),
        .wdata_i (mem_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= rd_acc;
        end
    end

    // Forwarding info captured with the read so the merge lines up with bank data.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fwd_hit_q  <= wr_acc && (wr_addr == rd_addr);
            fwd_be_q   <= wr_be;
            fwd_data_q <= din;
        end
    end

    assign fwd_be_eff = fwd_hit_q ? fwd_be_q : '0;
    assign merged     = DATA_W'(byte_merge(MAX_DATA_W'(bank_rdata),
                                           MAX_DATA_W'(fwd_data_q),
                                           MAX_BE_W'(fwd_be_eff)));

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] dout_q;
        logic              rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_v1_q;
                if (rd_v1_q) begin
                    dout_q <= merged;
                end
            end
        end

        assign dout     = dout_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_lat1
        // Bank register has no reset, so mask it until the first read after rst.
        logic hold_zero_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_zero_q <= 1'b1;
            end else if (rd_acc) begin
                hold_zero_q <= 1'b0;
            end
        end

        assign dout     = hold_zero_q ? '0 : merged;
        assign rd_valid = rd_v1_q;
    end

    assign init_done = init_done_q;
    assign init_viol = init_viol_q;

endmodule

// File: tb/tb_sram_be_init.sv
// Randomised self-checking bench: one RD_LAT=1 and one RD_LAT=2 instance share
// the same stimulus and are compared against a behavioural memory model.
module tb_sram_be_init;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [DW-1:0] INIT = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_be;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] dout1, dout2;
    logic          rdv1, rdv2, done1, done2, viol1, viol2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left;
    logic          m_done, m_viol;
    logic          e1_v, s1_v, e2_v;
    logic [DW-1:0] e1_d, s1_d, e2_d;

    always #5 clk = ~clk;

    sram_be_init #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL(INIT)) u_lat1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout1), .rd_valid(rdv1),
        .init_done(done1), .init_viol(viol1)
    );

    sram_be_init #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL(INIT)) u_lat2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout2), .rd_valid(rdv2),
        .init_done(done2), .init_viol(viol2)
    );

    wire [37:0] obs = {dout1, rdv1, dout2, rdv2, done1, done2, viol1, viol2};

    function automatic logic [37:0] exp_vec();
        return {e1_d, e1_v, e2_d, e2_v, m_done, m_done, m_viol, m_viol};
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic tick();
        logic [DW-1:0] word;
        logic [DW-1:0] mask;
        mask = {{8{wr_be[1]}}, {8{wr_be[0]}}};
        if (rst) begin
            sweep_left = DEPTH;
            m_done = 1'b0; m_viol = 1'b0;
            e1_v = 1'b0; e1_d = '0;
            s1_v = 1'b0; e2_v = 1'b0; e2_d = '0;
        end else if (!m_done) begin
            if (wr_en || rd_en) m_viol = 1'b1;
            e1_v = 1'b0;
            e2_v = s1_v;
            if (s1_v) e2_d = s1_d;
            s1_v = 1'b0;
            sweep_left--;
            if (sweep_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
                m_done = 1'b1;
            end
        end else begin
            word = m_mem[rd_addr];
            if (wr_en && wr_addr == rd_addr) word = (word & ~mask) | (din & mask);
            e2_v = s1_v;
            if (s1_v) e2_d = s1_d;
            s1_v = rd_en;
            s1_d = word;
            e1_v = rd_en;
            if (rd_en) e1_d = word;
            if (wr_en) m_mem[wr_addr] = (m_mem[wr_addr] & ~mask) | (din & mask);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if ({done1, viol1, rdv2, dout2, dout1} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_zero got=%h exp=0", {done1, viol1, rdv2, dout2, dout1});
        end
    endtask

    task automatic test_init_sweep();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL sweep cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i >= 15) begin
                n_checks++;
                if (done1 !== (i == 16)) begin
                    n_errors++;
                    $display("FAIL sweep_done cyc=%0d got=%b exp=%b", i, done1, (i == 16));
                end
            end
        end
        for (int a = 0; a < 18; a++) begin
            rd_en = (a < 16);
            rd_addr = AW'(a);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL init_read a=%0d got=%h exp=%h", a, obs, exp_vec());
            end
            if (a < 16) begin
                n_checks++;
                if (dout1 !== 16'hA5A5 || rdv1 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL init_value a=%0d got=%h/%b exp=a5a5/1", a, dout1, rdv1);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_enables();
        wr_en = 1'b1; wr_addr = 4'd3; wr_be = 2'b11; din = 16'h1234; tick();
        wr_be = 2'b10; din = 16'hFF00; tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3; tick();
        n_checks++;
        if (obs !== exp_vec() || dout1 !== 16'hFF34) begin
            n_errors++;
            $display("FAIL byte_en got=%h exp=%h dout=%h", obs, exp_vec(), dout1);
        end
        rd_en = 1'b0; tick();
        n_checks++;
        if (dout2 !== 16'hFF34 || rdv2 !== 1'b1 || rdv1 !== 1'b0) begin
            n_errors++;
            $display("FAIL byte_en_lat2 got=%h/%b exp=ff34/1", dout2, rdv2);
        end
    endtask

    task automatic test_rdw();
        wr_en = 1'b1; wr_addr = 4'd5; wr_be = 2'b11; din = 16'h1111; tick();
        wr_be = 2'b01; din = 16'h22CC; rd_en = 1'b1; rd_addr = 4'd5; tick();
        n_checks++;
        if (obs !== exp_vec() || dout1 !== 16'h11CC) begin
            n_errors++;
            $display("FAIL rdw_fwd got=%h exp=%h dout=%h", obs, exp_vec(), dout1);
        end
        wr_en = 1'b0; tick();
        n_checks++;
        if (obs !== exp_vec() || dout1 !== 16'h11CC || dout2 !== 16'h11CC) begin
            n_errors++;
            $display("FAIL rdw_after got=%h exp=%h", obs, exp_vec());
        end
        idle(); tick(); tick();
        n_checks++;
        if (obs !== exp_vec() || dout2 !== 16'h11CC || rdv2 !== 1'b0) begin
            n_errors++;
            $display("FAIL rdw_hold got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        logic          exp_rv [6];
        vals[0] = 16'h1001; vals[1] = 16'h2002; vals[2] = 16'h3003;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b1; exp_rv[2] = 1'b1;
        exp_rv[3] = 1'b1; exp_rv[4] = 1'b0; exp_rv[5] = 1'b0;
        wr_be = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k + 1); din = vals[k]; tick();
        end
        wr_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            rd_en = (t < 3);
            rd_addr = AW'(t + 1);
            tick();
            n_checks++;
            if (obs !== exp_vec() || rdv2 !== exp_rv[t]) begin
                n_errors++;
                $display("FAIL b2b t=%0d got=%h exp=%h", t, obs, exp_vec());
            end
            if (t >= 1 && t <= 3) begin
                n_checks++;
                if (dout2 !== vals[t-1]) begin
                    n_errors++;
                    $display("FAIL b2b_order t=%0d got=%h exp=%h", t, dout2, vals[t-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            wr_be   = 2'($urandom_range(0, 3));
            din     = 16'($urandom);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        idle(); tick();
    endtask

    task automatic test_flush();
        bit saw_valid;
        saw_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd3; tick();
        rd_en = 1'b0; rst = 1'b1; tick();
        n_checks++;
        if (obs !== exp_vec() || rdv2 !== 1'b0 || dout2 !== 16'h0000) begin
            n_errors++;
            $display("FAIL flush got=%h exp=%h", obs, exp_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rdv2 === 1'b1) saw_valid = 1'b1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL flush_after i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (saw_valid || dout2 !== 16'h0000) begin
            n_errors++;
            $display("FAIL flush_valid got=%b/%h exp=0/0000", saw_valid, dout2);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int cnt;
        rst = 1'b1; idle(); tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rd_en = (c == 2);
            rd_addr = 4'd0;
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL midsweep c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 2) begin
                n_checks++;
                if (viol1 !== 1'b1 || viol2 !== 1'b1 || rdv1 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL midsweep_viol got=%b%b%b exp=110", viol1, viol2, rdv1);
                end
            end
        end
        rd_en = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        cnt = 0;
        while (done1 !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL midsweep_restart cnt=%0d got=%h exp=%h", cnt, obs, exp_vec());
            end
        end
        n_checks++;
        if (cnt != 16) begin
            n_errors++;
            $display("FAIL midsweep_len got=%0d exp=16", cnt);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; din = '0;
        sweep_left = DEPTH; m_done = 1'b0; m_viol = 1'b0;
        e1_v = 1'b0; e1_d = '0; s1_v = 1'b0; s1_d = '0; e2_v = 1'b0; e2_d = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_init_sweep();
        test_byte_enables();
        test_rdw();
        test_back_to_back();
        test_random();
        test_flush();
        test_mid_sweep_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
